// File: rtl/pb_debounce_if.sv
// Pushbutton bundle between the raw KEY pins, the debouncer and its consumers.
// slave = the debouncer, master = the board/system side that supplies raw keys.
interface pb_debounce_if #(
   parameter int NUM_BTN = 4
);
   logic [NUM_BTN-1:0] btn_raw_n;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic               btn_any;

   modport master (
      output btn_raw_n,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_any
   );

   modport slave (
      input  btn_raw_n,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_any
   );
endinterface

// File: rtl/pb_debounce.sv
// Per-button 2-flop synchronizer, debouncer and press/release pulse generator.
// Define PB_AUTOREPEAT_EN to add auto-repeat pulses on btn_press while a button is held.
module pb_debounce #(
   parameter int NUM_BTN       = 4,
   parameter int STABLE_CYCLES = 500000,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   pb_debounce_if.slave btn
);

   localparam int               CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   generate
      if (STABLE_CYCLES < 2) begin : g_bad_stable
         $error("pb_debounce: STABLE_CYCLES must be >= 2");
      end
      if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
         $error("pb_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
      end
   endgenerate

   logic [NUM_BTN-1:0] sync1_n;
   logic [NUM_BTN-1:0] sync2_n;
   logic [NUM_BTN-1:0] level;
   logic [NUM_BTN-1:0] level_nxt;
   logic [NUM_BTN-1:0] accept;
   logic [NUM_BTN-1:0] rise;
   logic [NUM_BTN-1:0] fall;
   logic [NUM_BTN-1:0] press_nxt;
   logic [CNT_W-1:0]   cnt     [NUM_BTN];
   logic [CNT_W-1:0]   cnt_nxt [NUM_BTN];

   // A lane accepts s2 only after it has differed from the stable level for STABLE_CYCLES samples.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      level_nxt = level;
      accept    = '0;
      cnt_nxt   = cnt;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (~sync2_n[i] == level[i]) begin
            cnt_nxt[i] = '0;
         end else if (cnt[i] == CNT_LAST) begin
            level_nxt[i] = ~sync2_n[i];
            cnt_nxt[i]   = '0;
            accept[i]    = 1'b1;
         end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
         end
      end
   end

   assign rise = accept &  level_nxt;
   assign fall = accept & ~level_nxt;

`ifdef PB_AUTOREPEAT_EN
   localparam int               RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int               RPT_W     = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0]   rpt_cnt     [NUM_BTN];
   logic [RPT_W-1:0]   rpt_cnt_nxt [NUM_BTN];
   logic [NUM_BTN-1:0] rpt_seen;
   logic [NUM_BTN-1:0] rpt_seen_nxt;
   logic [NUM_BTN-1:0] rpt_fire;

   // rpt_seen marks that the first (longer) delay has elapsed; later pulses use the period.
   always_comb begin
      rpt_cnt_nxt  = rpt_cnt;
      rpt_seen_nxt = rpt_seen;
      rpt_fire     = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (accept[i]) begin
            rpt_cnt_nxt[i]  = '0;
            rpt_seen_nxt[i] = 1'b0;
         end else if (level[i]) begin
            if (rpt_cnt[i] == (rpt_seen[i] ? RPT_NEXT : RPT_FIRST)) begin
               rpt_fire[i]     = 1'b1;
               rpt_cnt_nxt[i]  = '0;
               rpt_seen_nxt[i] = 1'b1;
            end else begin
               rpt_cnt_nxt[i] = rpt_cnt[i] + RPT_W'(1);
            end
         end
      end
   end

   assign press_nxt = rise | rpt_fire;
`else
   assign press_nxt = rise;
`endif

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         sync1_n         <= '1;
         sync2_n         <= '1;
         level           <= '0;
         cnt             <= '{default: '0};
         btn.btn_press   <= '0;
         btn.btn_release <= '0;
         btn.btn_any     <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
         rpt_cnt         <= '{default: '0};
         rpt_seen        <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values (s1 -> s2 chain).
         sync1_n         <= btn.btn_raw_n;
         sync2_n         <= sync1_n;
         level           <= level_nxt;
         cnt             <= cnt_nxt;
         btn.btn_press   <= press_nxt;
         btn.btn_release <= fall;
         btn.btn_any     <= |level_nxt;
`ifdef PB_AUTOREPEAT_EN
         rpt_cnt         <= rpt_cnt_nxt;
         rpt_seen        <= rpt_seen_nxt;
`endif
      end
   end

   assign btn.btn_level = level;

endmodule

// File: tb/tb_pb_debounce.sv
// Scoreboard bench for pb_debounce: stimulus queues timed expected output events,
// a negedge monitor pops and compares whenever level changes or a pulse appears.
module tb_pb_debounce;
   localparam int NUM_BTN = 4;
   localparam int STABLE  = 4;
   localparam int RDELAY  = 20;
   localparam int RPERIOD = 8;
   // Drive at a negedge after edge n: s1 samples at n+1, btn_level changes on edge n+1+STABLE+1.
   localparam int LAT     = STABLE + 2;

   logic clk_clk = 1'b0;
   logic reset_reset_n;

   always #5 clk_clk = ~clk_clk;

   pb_debounce_if #(.NUM_BTN(NUM_BTN)) bus ();

   pb_debounce #(
      .NUM_BTN      (NUM_BTN),
      .STABLE_CYCLES(STABLE),
      .REPEAT_DELAY (RDELAY),
      .REPEAT_PERIOD(RPERIOD)
   ) dut (
      .clk_clk      (clk_clk),
      .reset_reset_n(reset_reset_n),
      .btn          (bus.slave)
   );

   typedef struct {
      int         cyc;
      logic [3:0] level;
      logic [3:0] press;
      logic [3:0] rel;
   } ev_t;

   ev_t exp_q[$];
   int  cyc    = 0;
   int  n_cmp  = 0;
   int  n_bad  = 0;

   always @(posedge clk_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void expect_ev(input int c, input logic [3:0] lv,
                                     input logic [3:0] pr, input logic [3:0] rl);
      ev_t e;
      e.cyc   = c;
      e.level = lv;
      e.press = pr;
      e.rel   = rl;
      exp_q.push_back(e);
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   // Monitor: an output event is any pulse or any change of btn_level.
   logic [3:0] prev_level = '0;
   always @(negedge clk_clk) begin
      logic is_ev;
      ev_t  e;
      is_ev      = (bus.btn_press != '0) || (bus.btn_release != '0) || (bus.btn_level != prev_level);
      prev_level = bus.btn_level;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         check("missed event", cyc, e.cyc);
      end
      if (is_ev) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected event: level=%b press=%b release=%b any=%b, want no event (cycle %0d)",
                     bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_any, cyc);
         end else begin
            e = exp_q.pop_front();
            check("event cycle", cyc, e.cyc);
            check("event value", {19'd0, bus.btn_any, bus.btn_level, bus.btn_press, bus.btn_release},
                  {19'd0, |e.level, e.level, e.press, e.rel});
         end
      end
   end

   initial begin
      #50000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: stimulus still running at cycle %0d, want done", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      int a;
      int rel_edge;
      reset_reset_n = 1'b0;
      bus.btn_raw_n = 4'b1110;

      // 1. Reset with bit 0 already held low.
      repeat (3) @(posedge clk_clk);
      @(negedge clk_clk);
      check("reset level",   {28'd0, bus.btn_level},   32'd0);
      check("reset press",   {28'd0, bus.btn_press},   32'd0);
      check("reset release", {28'd0, bus.btn_release}, 32'd0);
      check("reset any",     {31'd0, bus.btn_any},     32'd0);
      reset_reset_n = 1'b1;
      expect_ev(cyc + LAT, 4'b0001, 4'b0001, 4'b0000);
      idle(12);

      // 2. Clean press on bit 1.
      bus.btn_raw_n[1] = 1'b0;
      expect_ev(cyc + LAT, 4'b0011, 4'b0010, 4'b0000);
      idle(12);

      // 3. Bounce on bit 2: 3-cycle phases never reach the stable window.
      bus.btn_raw_n[2] = 1'b0; idle(3);
      bus.btn_raw_n[2] = 1'b1; idle(3);
      bus.btn_raw_n[2] = 1'b0; idle(3);
      bus.btn_raw_n[2] = 1'b1; idle(3);
      bus.btn_raw_n[2] = 1'b0;
      expect_ev(cyc + LAT, 4'b0111, 4'b0100, 4'b0000);
      idle(12);

      // 4. Release bit 0 and press bit 3 together.
      bus.btn_raw_n[0] = 1'b1;
      bus.btn_raw_n[3] = 1'b0;
      expect_ev(cyc + LAT, 4'b1110, 4'b1000, 4'b0001);
      idle(12);

      // Release bits 1..3 together.
      bus.btn_raw_n = 4'b1111;
      expect_ev(cyc + LAT, 4'b0000, 4'b0000, 4'b1110);
      idle(12);

      // 5. Reset two counts into a press on bit 0; the full window restarts afterwards.
      bus.btn_raw_n[0] = 1'b0;
      idle(4);
      reset_reset_n = 1'b0;
      idle(2);
      reset_reset_n = 1'b1;
      a        = cyc + LAT;
      rel_edge = a + 58 + LAT;
      expect_ev(a, 4'b0001, 4'b0001, 4'b0000);

      // 6. Hold bit 0 for 58 more cycles, then release.
`ifdef PB_AUTOREPEAT_EN
      for (int t = a + RDELAY; t < rel_edge; t += RPERIOD)
         expect_ev(t, 4'b0001, 4'b0001, 4'b0000);
`endif
      while (cyc < a + 58) @(negedge clk_clk);
      bus.btn_raw_n[0] = 1'b1;
      expect_ev(rel_edge, 4'b0000, 4'b0000, 4'b0001);
      idle(20);

      check("queue drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pb_debounce.md
Name: pb_debounce

Overview:
- Per-button synchronizer, debouncer and edge detector for the board pushbuttons.
- Sits directly upstream of the Nios system's pushbutton PIO: btn_level drives the system's 4-bit pushbuttons_export input.
- Raw KEY inputs are asynchronous and active-low. All outputs are clean, active-high and in the clk_clk domain.
- Press/release pulses are also available to fabric logic.

Parameters:
- NUM_BTN, 4: number of buttons.
- STABLE_CYCLES, 500000: consecutive stable cycles needed to accept a new level (10 ms at 50 MHz). Must be >= 2.
- REPEAT_DELAY, 25000000: cycles from an accepted press to the first auto-repeat pulse. Used only with PB_AUTOREPEAT_EN.
- REPEAT_PERIOD, 5000000: cycles between later auto-repeat pulses. Used only with PB_AUTOREPEAT_EN.

Ports:
- clk_clk, input, 1: system clock.
- reset_reset_n, input, 1: synchronous, active-low reset.
- btn_raw_n, input, NUM_BTN: raw pushbuttons; 0 = pressed; asynchronous.
- btn_level, output, NUM_BTN: debounced level; 1 = pressed. Connects to pushbuttons_export.
- btn_press, output, NUM_BTN: one-cycle pulse per accepted press (plus repeats when enabled).
- btn_release, output, NUM_BTN: one-cycle pulse per accepted release.
- btn_any, output, 1: OR of btn_level.

Behaviour:
- One clock, clk_clk. Reset is synchronous and active-low: sampled on the rising edge of clk_clk while reset_reset_n = 0.
- Reset values:
  - synchronizer flops = 1 (released);
  - stable state = released;
  - counters = 0;
  - btn_level, btn_press, btn_release, btn_any = 0.
- Reset mid-count discards partial progress. After reset release, a button held low must again be stable for the full STABLE_CYCLES before btn_level rises.
- Synchronizer: 2-flop per bit (s1, s2) with no logic between the flops. The debouncer consumes only s2.
- Debounce, per bit, independent:
  - Counter width = clog2(STABLE_CYCLES).
  - If s2 equals the stable state: counter <= 0.
  - Else if counter == STABLE_CYCLES-1: stable state <= s2, counter <= 0.
  - Else: counter <= counter+1.
- Latency: let edge 0 be the first edge where s1 samples the new raw level, held steady. btn_level changes on edge STABLE_CYCLES+1.
- Bounce: any cycle where s2 returns to the stable state clears the counter. Glitches shorter than STABLE_CYCLES never reach btn_level.
- Edge pulses:
  - btn_press asserts for exactly one cycle, registered on the same edge btn_level goes 0->1.
  - btn_release does the same on 1->0.
  - Never both on one bit in one cycle.
- Simultaneous events: bits are fully independent. Several bits may pulse in the same cycle.
- Counter never exceeds STABLE_CYCLES-1 and has no wrap-around.
- btn_any is registered; it is the OR of the next btn_level value, so it is cycle-aligned with btn_level.

Optional Feature:
- Macro: PB_AUTOREPEAT_EN.
- Defined:
  - Each bit gets a repeat counter, cleared on the accepted press.
  - While btn_level stays 1, btn_press re-pulses REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
  - An accepted release clears the repeat counter immediately. No repeat pulse occurs in the release cycle or after it.
- Not defined: no repeat logic or counters are synthesized. btn_press pulses exactly once per accepted press. REPEAT_* parameters are ignored.

Test Plan (bench uses STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
1. Reset: hold reset_reset_n=0 for 3 cycles with btn_raw_n=4'b1110 -> all outputs 0. After release, btn_level=4'b0001 at edge 5 (counting from the first edge with reset_reset_n=1), plus one btn_press[0] pulse.
2. Clean press: drive btn_raw_n[1] 1->0 and hold -> btn_level[1]=1 exactly 5 edges after s1 samples 0. btn_press[1] high for exactly 1 cycle. btn_any=1 in the same cycle.
3. Bounce: toggle btn_raw_n[2] 0,1,0,1 with 3-cycle phases, then hold 0 -> no output change during bouncing. btn_level[2] rises 5 edges after the final 0 is sampled; exactly one press pulse.
4. Simultaneous: release bit 0 and press bit 3 on the same edge -> btn_release[0] and btn_press[3] pulse in the same cycle. btn_level updates both bits together.
5. Reset mid-count: assert reset 2 cycles into a press count, then release with the button held -> btn_level stays 0 for the full new window, then rises.
6. PB_AUTOREPEAT_EN: hold btn_raw_n[0]=0 for 60 cycles -> btn_press[0] pulses at accept, +20, +28, +36, ... Releasing stops the pulses and gives one btn_release[0] pulse. Without the macro, only the first pulse appears.
